// File: rtl/reg_pipe_n.sv
// Parametrised DEPTH-stage register pipeline with valid tracking, clock-enable stall and sync clear.
// Optional occupancy counter port OCC is built only when REG_PIPE_OCC_EN is defined.
module reg_pipe_n #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 1,
    localparam int unsigned OW   = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             SRST,
    input  logic [WIDTH-1:0] IN,
    input  logic             VLD_IN,
    output logic [WIDTH-1:0] OUT,
    output logic             VLD_OUT
`ifdef REG_PIPE_OCC_EN
   ,output logic [OW-1:0]    OCC
`endif
);

    if (DEPTH == 0) begin : g_bypass
        // Pure wire: clock, enable and both resets have no effect.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, CLK, RST_N, CE, SRST};
        assign OUT         = IN;
        assign VLD_OUT     = VLD_IN;
`ifdef REG_PIPE_OCC_EN
        assign OCC         = '0;
`endif
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];
        logic [DEPTH-1:0] vld;

        // Data shifts on every enabled edge regardless of VLD_IN; vld alone marks meaning.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
                vld <= '0;
            end else if (SRST) begin
                for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
                vld <= '0;
            end else if (CE) begin
                stage[0] <= IN;
                vld[0]   <= VLD_IN;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    stage[k] <= stage[k-1];
                    vld[k]   <= vld[k-1];
                end
            end
        end

        assign OUT     = stage[DEPTH-1];
        assign VLD_OUT = vld[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
        logic [OW-1:0] occ_q;

        // Tracks the number of set vld flags; bounded by DEPTH so it cannot wrap.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                occ_q <= '0;
            end else if (SRST) begin
                occ_q <= '0;
            end else if (CE) begin
                occ_q <= occ_q + OW'(VLD_IN) - OW'(vld[DEPTH-1]);
            end
        end

        assign OCC = occ_q;
`endif
    end

endmodule

// File: tb/tb_reg_pipe_n.sv
// Self-checking bench for reg_pipe_n at DEPTH 0/2/3/4 sharing one stimulus stream.
// Builds with or without REG_PIPE_OCC_EN; occupancy checks appear only when it is defined.
module tb_reg_pipe_n;

    logic        CLK = 1'b0;
    logic        RST_N, CE, SRST, VLD_IN;
    logic [17:0] IN;
    logic [17:0] out0, out2, out3, out4;
    logic        vld0, vld2, vld3, vld4;
`ifdef REG_PIPE_OCC_EN
    logic [0:0]  occ0;
    logic [1:0]  occ2, occ3;
    logic [2:0]  occ4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    reg_pipe_n #(.WIDTH(18), .DEPTH(0)) u_d0 (.CLK(CLK), .RST_N(RST_N), .CE(CE), .SRST(SRST),
        .IN(IN), .VLD_IN(VLD_IN), .OUT(out0), .VLD_OUT(vld0)
`ifdef REG_PIPE_OCC_EN
        , .OCC(occ0)
`endif
    );
    reg_pipe_n #(.WIDTH(18), .DEPTH(2)) u_d2 (.CLK(CLK), .RST_N(RST_N), .CE(CE), .SRST(SRST),
        .IN(IN), .VLD_IN(VLD_IN), .OUT(out2), .VLD_OUT(vld2)
`ifdef REG_PIPE_OCC_EN
        , .OCC(occ2)
`endif
    );
    reg_pipe_n #(.WIDTH(18), .DEPTH(3)) u_d3 (.CLK(CLK), .RST_N(RST_N), .CE(CE), .SRST(SRST),
        .IN(IN), .VLD_IN(VLD_IN), .OUT(out3), .VLD_OUT(vld3)
`ifdef REG_PIPE_OCC_EN
        , .OCC(occ3)
`endif
    );
    reg_pipe_n #(.WIDTH(18), .DEPTH(4)) u_d4 (.CLK(CLK), .RST_N(RST_N), .CE(CE), .SRST(SRST),
        .IN(IN), .VLD_IN(VLD_IN), .OUT(out4), .VLD_OUT(vld4)
`ifdef REG_PIPE_OCC_EN
        , .OCC(occ4)
`endif
    );

    // Reference: history of {vld,data} captured on enabled edges since the last clear.
    logic [18:0] hist [$];

    function automatic logic [18:0] m_out(input int d);
        if (d == 0) return {VLD_IN, IN};
        if (hist.size() >= d) return hist[hist.size() - d];
        return 19'd0;
    endfunction

    function automatic int m_occ(input int d);
        int n = 0;
        for (int i = 0; i < d; i++)
            if (hist.size() > i && hist[hist.size() - 1 - i][18]) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [18:0] e;
        e = m_out(0); check("d0_out", 32'(out0), 32'(e[17:0])); check("d0_vld", 32'(vld0), 32'(e[18]));
        e = m_out(2); check("d2_out", 32'(out2), 32'(e[17:0])); check("d2_vld", 32'(vld2), 32'(e[18]));
        e = m_out(3); check("d3_out", 32'(out3), 32'(e[17:0])); check("d3_vld", 32'(vld3), 32'(e[18]));
        e = m_out(4); check("d4_out", 32'(out4), 32'(e[17:0])); check("d4_vld", 32'(vld4), 32'(e[18]));
`ifdef REG_PIPE_OCC_EN
        check("d0_occ", 32'(occ0), 32'd0);
        check("d2_occ", 32'(occ2), 32'(m_occ(2)));
        check("d3_occ", 32'(occ3), 32'(m_occ(3)));
        check("d4_occ", 32'(occ4), 32'(m_occ(4)));
`endif
    endtask

    // Advance one edge, update the reference with the inputs seen at that edge, then compare.
    task automatic tick();
        @(posedge CLK);
        if (!RST_N || SRST) hist.delete();
        else if (CE) begin
            hist.push_back({VLD_IN, IN});
            if (hist.size() > 8) void'(hist.pop_front());
        end
        #1;
        check_all();
    endtask

    typedef struct {
        logic        ce;
        logic        srst;
        logic [17:0] din;
        logic        vin;
        logic [17:0] eout;
        logic        evld;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic ce, input logic srst, input logic [17:0] din, input logic vin,
                       input logic [17:0] eout, input logic evld);
        vec_t v;
        v.ce = ce; v.srst = srst; v.din = din; v.vin = vin; v.eout = eout; v.evld = evld;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected DEPTH=3 output after each edge: latency, stall, clear-priority sequences.
        add(1,1,18'h0,0,     18'h0,0);
        add(1,0,18'h1,1,     18'h0,0);
        add(1,0,18'h2,1,     18'h0,0);
        add(1,0,18'h3,1,     18'h1,1);
        add(1,0,18'h0,0,     18'h2,1);
        add(1,0,18'h0,0,     18'h3,1);
        add(1,0,18'h0,0,     18'h0,0);
        add(1,0,18'h11,1,    18'h0,0);
        add(1,0,18'h22,1,    18'h0,0);
        add(1,0,18'h33,1,    18'h11,1);
        for (int i = 0; i < 5; i++) add(0,0,18'h3C,1, 18'h11,1);
        add(1,0,18'h0,0,     18'h22,1);
        add(1,0,18'h0,0,     18'h33,1);
        add(1,0,18'h0,0,     18'h0,0);
        add(1,0,18'hA,1,     18'h0,0);
        add(1,0,18'hB,1,     18'h0,0);
        add(0,1,18'h3FFFF,1, 18'h0,0);
        add(1,0,18'h5,1,     18'h0,0);
        add(1,0,18'h0,0,     18'h0,0);
        add(1,0,18'h0,0,     18'h5,1);

        RST_N = 1'b0; CE = 1'b0; SRST = 1'b0; IN = 18'h0; VLD_IN = 1'b0;
        #2;
        hist.delete();
        check_all();
        check("reset_d4_out", 32'(out4), 32'd0);
        #1 RST_N = 1'b1;

        foreach (vecs[i]) begin
            CE = vecs[i].ce; SRST = vecs[i].srst; IN = vecs[i].din; VLD_IN = vecs[i].vin;
            tick();
            check($sformatf("tbl%0d_out", i), 32'(out3), 32'(vecs[i].eout));
            check($sformatf("tbl%0d_vld", i), 32'(vld3), 32'(vecs[i].evld));
        end

        // Async reset mid-cycle with stages loaded clears outputs before the next edge.
        CE = 1'b1; SRST = 1'b0; IN = 18'h155; VLD_IN = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        RST_N = 1'b0;
        #2;
        hist.delete();
        check("rst_mid_out", 32'(out3), 32'd0);
        check("rst_mid_vld", 32'(vld3), 32'd0);
        check_all();
        RST_N = 1'b1;
        IN = 18'h2F0F0;
        tick();
        check("post_rst_vld", 32'(vld3), 32'd0);

        // Bypass follows IN combinationally whatever CE/SRST do.
        IN = 18'h2AAAA; VLD_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CE = i[0]; SRST = i[1];
            #1;
            check("bypass_out", 32'(out0), 32'h2AAAA);
            check("bypass_vld", 32'(vld0), 32'd1);
        end

`ifdef REG_PIPE_OCC_EN
        CE = 1'b1; SRST = 1'b1; tick(); SRST = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            IN = 18'(i); VLD_IN = 1'b1;
            tick();
            check("occ_fill", 32'(occ4), 32'(i));
        end
        for (int i = 3; i >= 0; i--) begin
            VLD_IN = 1'b0;
            tick();
            check("occ_drain", 32'(occ4), 32'(i));
        end
`endif

        // Random traffic with occasional stalls, clears and async resets.
        for (int i = 0; i < 400; i++) begin
            CE     = ($urandom_range(0, 3) != 0);
            SRST   = ($urandom_range(0, 19) == 0);
            VLD_IN = $urandom_range(0, 1) == 1;
            IN     = 18'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                RST_N = 1'b0;
                #1;
                hist.delete();
                check_all();
                RST_N = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
